// File: rtl/jc_sched_pkg.sv
// jc_sched_pkg: shared constants and types for the Johnson-counter slot scheduler
package jc_sched_pkg;
    localparam int          NUM_SLOTS    = 8;
    localparam int          NUM_REQ_DEF  = 4;
    localparam logic [15:0] SLOT_MAP_DEF = 16'hE4E4;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam logic [3:0] JC_CODE [NUM_SLOTS] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000
    };
endpackage

// File: rtl/jc_slot_scheduler_if.sv
// jc_slot_scheduler_if: control/request inputs and phase/grant outputs of the scheduler
//   master: drives start, stop, oneshot, req; observes phase, slot, grant, busy, frame_done, err
//   slave : the scheduler side of the same signals
interface jc_slot_scheduler_if import jc_sched_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF
) ();
    logic               start;
    logic               stop;
    logic               oneshot;
    logic [NUM_REQ-1:0] req;
    logic [7:0]         phase;
    logic [2:0]         slot;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               frame_done;
    logic               err;
    modport master (
        output start, stop, oneshot, req,
        input  phase, slot, grant, busy, frame_done, err
    );
    modport slave (
        input  start, stop, oneshot, req,
        output phase, slot, grant, busy, frame_done, err
    );
endinterface

// File: rtl/jc4_phase_gen.sv
// jc4_phase_gen: 4-bit Johnson counter with hold/clear, illegal-state recovery and phase decode
//   clk, async_reset (active-low, async) | hold: keep Q | clr: force Q to 0000
//   phase: one-hot T0..T7 (0 on illegal Q) | slot: binary slot | last: slot 7 | err: illegal Q
module jc4_phase_gen import jc_sched_pkg::*; (
    input  logic       clk,
    input  logic       async_reset,
    input  logic       hold,
    input  logic       clr,
    output logic [7:0] phase,
    output logic [2:0] slot,
    output logic       last,
    output logic       err
);
    logic [3:0] q_q, q_d;
    logic [7:0] dec;
    logic       legal;
    always_comb begin
        legal = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) legal = legal | (q_q == JC_CODE[i]);
        dec[0] = ~q_q[3] & ~q_q[0];
        dec[1] = ~q_q[1] &  q_q[0];
        dec[2] = ~q_q[2] &  q_q[1];
        dec[3] = ~q_q[3] &  q_q[2];
        dec[4] =  q_q[3] &  q_q[0];
        dec[5] =  q_q[1] & ~q_q[0];
        dec[6] =  q_q[2] & ~q_q[1];
        dec[7] =  q_q[3] & ~q_q[2];
        phase  = legal ? dec : 8'h00;
        slot   = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) if (phase[i]) slot = 3'(i);
        last   = phase[7];
        err    = ~legal;
        // an illegal code always recovers to slot 0, regardless of hold
        q_d    = (!legal || clr) ? 4'b0000 : hold ? q_q : {q_q[2:0], ~q_q[3]};
    end
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) q_q <= 4'b0000;
        else              q_q <= q_d;
    end
endmodule

// File: rtl/jc_slot_scheduler.sv
// jc_slot_scheduler: 8-slot time-division scheduler with static owners and round-robin spare slots
//   clk, async_reset (active-low, async)
//   bus.start/stop/oneshot: frame control | bus.req: level requests
//   bus.phase/slot: timing phase | bus.grant: one-hot slot grant | bus.busy/frame_done/err: status
module jc_slot_scheduler import jc_sched_pkg::*; #(
    parameter int          NUM_REQ  = NUM_REQ_DEF,
    parameter logic [15:0] SLOT_MAP = SLOT_MAP_DEF
) (
    input logic                clk,
    input logic                async_reset,
    jc_slot_scheduler_if.slave bus
);
    state_e             state_q, state_d;
    logic               stop_pend_q, stop_pend_d;
    logic               oneshot_q, oneshot_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         gen_phase;
    logic [2:0]         gen_slot, nxt_slot;
    logic               gen_last, gen_err, hold, clr, enter, found, busy;
    logic [1:0]         owner, idx;

    jc4_phase_gen u_gen (
        .clk         (clk),
        .async_reset (async_reset),
        .hold        (hold),
        .clr         (clr),
        .phase       (gen_phase),
        .slot        (gen_slot),
        .last        (gen_last),
        .err         (gen_err)
    );

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        oneshot_d   = oneshot_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = '0;
        hold        = 1'b1;
        clr         = 1'b0;
        enter       = 1'b0;
        found       = 1'b0;
        idx         = 2'd0;
        // slot the counter moves into on this edge; illegal codes recover to slot 0
        nxt_slot    = (gen_err || gen_last) ? 3'd0 : gen_slot + 3'd1;
        if (state_q == IDLE) begin
            if (bus.start && !bus.stop) begin
                state_d     = RUN;
                oneshot_d   = bus.oneshot;
                stop_pend_d = 1'b0;
                enter       = 1'b1;
                nxt_slot    = 3'd0;
            end
        end else begin
            hold        = 1'b0;
            stop_pend_d = stop_pend_q | bus.stop;
            // a stop arriving during slot 7 still ends this frame
            if (gen_last && (oneshot_q || stop_pend_d)) begin
                state_d     = IDLE;
                clr         = 1'b1;
                stop_pend_d = 1'b0;
                oneshot_d   = 1'b0;
            end else begin
                enter = 1'b1;
            end
        end
        owner = SLOT_MAP[2*nxt_slot +: 2];
        if (enter) begin
            if (bus.req[owner]) begin
                grant_d[owner] = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    idx = rr_ptr_q + 2'(i);
                    if (!found && bus.req[idx]) begin
                        found        = 1'b1;
                        grant_d[idx] = 1'b1;
                        rr_ptr_d     = idx + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
            oneshot_q   <= 1'b0;
            rr_ptr_q    <= 2'd0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            oneshot_q   <= oneshot_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
        end
    end

    assign busy           = state_q == RUN;
    assign bus.busy       = busy;
    assign bus.phase      = busy ? gen_phase : 8'h00;
    assign bus.slot       = busy ? gen_slot : 3'd0;
    assign bus.grant      = (busy && !gen_err) ? grant_q : '0;
    assign bus.frame_done = busy & gen_phase[7];
    assign bus.err        = gen_err;
endmodule

// File: tb/tb_jc_slot_scheduler.sv
// tb_jc_slot_scheduler: table-driven frame vectors with a scoreboard plus hand-written corner cases
module tb_jc_slot_scheduler;
    typedef struct packed {
        logic [7:0] phase;
        logic [2:0] slot;
        logic [3:0] grant;
        logic       busy;
        logic       fd;
        logic       err;
    } obs_t;
    typedef struct packed {
        logic [3:0]  req;
        logic        os;
        logic [31:0] g;
    } vec_t;

    logic clk = 1'b0;
    logic async_reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    obs_t sbq [$];

    jc_slot_scheduler_if #(.NUM_REQ(4)) bus ();
    jc_slot_scheduler #(.NUM_REQ(4), .SLOT_MAP(16'hE4E4)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return '{phase:bus.phase, slot:bus.slot, grant:bus.grant, busy:bus.busy, fd:bus.frame_done, err:bus.err};
    endfunction

    function automatic obs_t exp_slot(int s, logic [3:0] g);
        return '{phase:8'(1 << s), slot:3'(s), grant:g, busy:1'b1, fd:(s == 7), err:1'b0};
    endfunction

    task automatic chk_obs(string name, obs_t e);
        obs_t a = cur();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got phase=%h slot=%0d grant=%h busy=%b fd=%b err=%b, need phase=%h slot=%0d grant=%h busy=%b fd=%b err=%b",
                     name, a.phase, a.slot, a.grant, a.busy, a.fd, a.err, e.phase, e.slot, e.grant, e.busy, e.fd, e.err);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, need %0h", name, act, e);
        end
    endtask

    task automatic do_reset();
        async_reset = 1'b0;
        #1;
        chk_obs("reset state", '0);
        @(negedge clk);
        async_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, need finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [6];
        int   nf;
        obs_t bad;
        vt[0] = '{req:4'b1111, os:1'b1, g:32'h8421_8421};
        vt[1] = '{req:4'b0001, os:1'b0, g:32'h1111_1111};
        vt[2] = '{req:4'b0110, os:1'b0, g:32'h4422_4422};
        vt[3] = '{req:4'b0000, os:1'b0, g:32'h0000_0000};
        vt[4] = '{req:4'b1000, os:1'b0, g:32'h8888_8888};
        vt[5] = '{req:4'b1010, os:1'b0, g:32'h8822_8822};
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.oneshot = 1'b0;
        bus.req = 4'b0000;
        #1;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.req = vt[v].req;
            bus.start = 1'b1;
            bus.oneshot = vt[v].os;
            nf = vt[v].os ? 1 : 2;
            for (int f = 0; f < nf; f++)
                for (int s = 0; s < 8; s++) sbq.push_back(exp_slot(s, vt[v].g[4*s +: 4]));
            sbq.push_back('0);
            for (int c = 0; sbq.size() > 0 && c < 40; c++) begin
                @(negedge clk);
                bus.start = 1'b0;
                bus.oneshot = 1'b0;
                chk_obs($sformatf("vec%0d cyc%0d", v, c), sbq.pop_front());
                bus.stop = (!vt[v].os && c == 11);
            end
            bus.stop = 1'b0;
            chk($sformatf("vec%0d scoreboard drained", v), sbq.size(), 0);
            if (v == 2) chk("rr_ptr after spare-slot frames", 32'(dut.rr_ptr_q), 3);
        end

        do_reset();
        bus.req = 4'b1111;
        bus.start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("slot before mid-run reset", bus.slot, 3);
        #2 async_reset = 1'b0;
        #1 chk_obs("async reset mid-run", '0);
        @(negedge clk);
        async_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_obs("idle after reset release", '0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk_obs("restart shows slot 0", exp_slot(0, 4'b0001));
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
        chk("busy drops after stop", bus.busy, 0);

        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        chk_obs("start+stop in idle", '0);
        @(negedge clk);
        chk_obs("still idle after start+stop", '0);

        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("slot before illegal force", bus.slot, 2);
        #1 force dut.u_gen.q_q = 4'b0101;
        #1;
        bad = '{phase:8'h00, slot:3'd0, grant:4'b0000, busy:1'b1, fd:1'b0, err:1'b1};
        chk_obs("illegal Q cycle", bad);
        #1 release dut.u_gen.q_q;
        @(negedge clk);
        chk("recovered phase", bus.phase, 8'h01);
        chk("recovered slot", bus.slot, 0);
        chk("recovered err", bus.err, 0);
        chk("recovered busy", bus.busy, 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
        chk_obs("idle after illegal run", '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jc_slot_scheduler.md
Name: jc_slot_scheduler

Overview:
- Time-division scheduler built around an 8-phase Johnson-counter timing generator.
- Sequences the phase generator with start, stop and one-shot control.
- Hands each of the 8 timing slots to one of NUM_REQ requesters:
  - a static owner map decides who normally gets each slot;
  - unused slots are redistributed round-robin (work-conserving).
- Sits between the timing generator and the shared datapath/bus it gates.

Parameters:
- NUM_REQ, 4, number of requesters (fixed 4 in this revision; 2-bit owner fields).
- SLOT_MAP, 16'hE4E4, owner of slot s in bits [2s+1:2s]. Default owners for slots 0..7 are 0,1,2,3,0,1,2,3.

Ports:
- clk  in  1  clock.
- async_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin frames.
- stop  in  1  one-cycle pulse; stop at end of current frame.
- oneshot  in  1  sampled with start; 1 = run exactly one frame.
- req  in  NUM_REQ  level requests.
- phase  out  8  one-hot timing phase, T0..T7.
- slot  out  3  binary index of active phase.
- grant  out  NUM_REQ  one-hot grant for the current slot.
- busy  out  1  high while running.
- frame_done  out  1  high during slot 7 of every frame.
- err  out  1  illegal counter state detected.

Behaviour:
- Reset (async_reset=0, takes effect immediately):
  - Johnson counter Q=4'b0000, FSM=IDLE, rr_ptr=0, stop_pending=0, oneshot_lat=0.
  - All outputs are 0.
- Johnson counter:
  - Advance rule: Q <= {Q[2:0], ~Q[3]}.
  - Legal sequence: 0000,0001,0011,0111,1111,1110,1100,1000, which are slots 0..7.
  - Phase decode:
    - T0=~Q3&~Q0
    - T1=~Q1&Q0
    - T2=~Q2&Q1
    - T3=~Q3&Q2
    - T4=Q3&Q0
    - T5=Q1&~Q0
    - T6=Q2&~Q1
    - T7=Q3&~Q2
- Illegal Q (any of the other 8 codes):
  - That cycle: err=1, phase=0, grant=0, frame_done=0.
  - Next edge forces Q=0000. FSM state is unchanged.
- FSM IDLE:
  - Q held at 0000; phase, grant, busy and frame_done are all 0.
  - start=1 and stop=0: go to RUN, latch oneshot. The next cycle shows slot 0 (Q stays 0000 on this edge).
  - start=1 and stop=1 together: stop wins; remain IDLE.
- FSM RUN:
  - busy=1; phase is the decoded Q.
  - Q advances every edge.
  - stop sets stop_pending (sticky). A start while in RUN is ignored.
  - At the edge leaving slot 7:
    - if oneshot_lat or stop_pending (including a stop arriving during slot 7 itself): go to IDLE, Q=0000, clear both flags;
    - otherwise wrap to slot 0.
- Grant rule, registered with phase (latency 1):
  - On each edge entering slot s in RUN, grant is computed from req sampled at that edge.
  - If owner(s) is requesting: grant the owner; rr_ptr is unchanged.
  - Otherwise: grant the first requester found scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. Set rr_ptr to (winner+1) mod NUM_REQ.
  - If no requester is active: grant=0, rr_ptr unchanged.
  - Grant is held exactly one cycle (one slot) and is always 0 outside RUN.
- Reset mid-frame: outputs clear asynchronously; the frame is abandoned and no frame_done is produced.

Decomposition:
- Shared package jc_sched_pkg holds:
  - slot-count constant (8) and NUM_REQ default;
  - FSM state enum {IDLE, RUN};
  - default SLOT_MAP;
  - the 8 legal Johnson codes, as a constant array indexed by slot.
- Sub-module jc4_phase_gen contains:
  - the 4-bit Johnson register with hold/clear inputs;
  - the illegal-state recovery;
  - the phase and slot decode, plus the err output.
- jc_slot_scheduler contains the FSM, the stop/oneshot latches, and the owner/round-robin grant logic.

Test Plan:
- Reset: assert async_reset=0 mid-RUN at slot 3 -> phase, grant, busy and slot go to 0 before the next edge. After release, the block idles until start.
- One-shot, full load: start+oneshot=1, req=4'b1111 -> phase 01,02,04,08,10,20,40,80 on 8 consecutive cycles; grant 1,2,4,8,1,2,4,8; frame_done=1 only with phase 80; busy=0 on the following cycle.
- Work-conserving: continuous run, req=4'b0001 -> grant=4'b0001 in all 8 slots of every frame.
- Round-robin spare slots: continuous run, req=4'b0110, rr_ptr=0 -> grants per slot 0..7 are 2,2,4,4,2,2,4,4 (one-hot values); rr_ptr ends the frame at 3.
- Stop handling:
  - stop pulsed during slot 3 -> slots 4..7 still run; frame_done=1 at slot 7; busy=0 next.
  - start and stop pulsed together in IDLE -> stays IDLE.
- Illegal state: force Q=4'b0101 in RUN -> err=1, phase=0, grant=0 that cycle. The next cycle shows phase=01, slot=0, err=0.
